axi_core_bridge: RTL and testbench

AXI4 slave to core-bus master bridge: the responder-side counterpart of the core-to-AXI bridge. It accepts AXI4 read and write bursts from an interconnect master and replays each beat as a single core-bus access (addr/read/write/waitrequest style) toward on-board register blocks and memories. One transaction is in flight at a time. Read and write requests are arbitrated round-robin.

---
 rtl/axi_core_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_core_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_core_bridge.sv
// rtl/axi_core_bridge.sv - AXI4 slave to core-bus master bridge replaying each beat as one bus access
// Optional waitrequest watchdog enabled by defining AXI_CORE_BRIDGE_TIMEOUT_EN
`timescale 1ns/1ps
module axi_core_bridge #(
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   slv_axi_awid,
    input  logic [ADDR_W-1:0] slv_axi_awaddr,
    input  logic [7:0]        slv_axi_awlen,
    input  logic [2:0]        slv_axi_awsize,
    input  logic [1:0]        slv_axi_awburst,
    input  logic              slv_axi_awvalid,
    output logic              slv_axi_awready,
    input  logic [31:0]       slv_axi_wdata,
    input  logic [3:0]        slv_axi_wstrb,
    input  logic              slv_axi_wlast,
    input  logic              slv_axi_wvalid,
    output logic              slv_axi_wready,
    output logic [ID_W-1:0]   slv_axi_bid,
    output logic [1:0]        slv_axi_bresp,
    output logic              slv_axi_bvalid,
    input  logic              slv_axi_bready,
    input  logic [ID_W-1:0]   slv_axi_arid,
    input  logic [ADDR_W-1:0] slv_axi_araddr,
    input  logic [7:0]        slv_axi_arlen,
    input  logic [2:0]        slv_axi_arsize,
    input  logic [1:0]        slv_axi_arburst,
    input  logic              slv_axi_arvalid,
    output logic              slv_axi_arready,
    output logic [ID_W-1:0]   slv_axi_rid,
    output logic [31:0]       slv_axi_rdata,
    output logic [1:0]        slv_axi_rresp,
    output logic              slv_axi_rlast,
    output logic              slv_axi_rvalid,
    input  logic              slv_axi_rready,
    output logic [ADDR_W-1:0] mst_bus_addr,
    output logic              mst_bus_read,
    output logic              mst_bus_write,
    output logic [31:0]       mst_bus_writedata,
    output logic [3:0]        mst_bus_byteenable,
    input  logic [31:0]       mst_bus_readdata,
    input  logic [1:0]        mst_bus_response,
    input  logic              mst_bus_waitrequest
);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_BUS, WR_RESP, RD_BUS, RD_RESP} state_t;

    state_t            state_q, state_d;
    logic              last_wr_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_q;
    logic              size_ok_q;
    logic              fixed_q;
    logic [1:0]        bresp_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    logic              grant_wr, grant_rd;
    logic              bus_stall, timeout_hit, bus_accept, beat_err, last_beat;
    logic [1:0]        beat_resp;
    logic [31:0]       beat_rdata;
    logic [ADDR_W-1:0] next_addr;
    logic              unused_in;

    assign unused_in = slv_axi_wlast;

    // Round-robin: on contention the channel not served last wins
    assign grant_wr = slv_axi_awvalid && (!slv_axi_arvalid || !last_wr_q);
    assign grant_rd = slv_axi_arvalid && !grant_wr;

    assign bus_stall = (mst_bus_read || mst_bus_write) && mst_bus_waitrequest;

`ifdef AXI_CORE_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    assign timeout_hit = bus_stall && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !bus_stall || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign timeout_hit    = 1'b0;
`endif

    // Unsupported sizes never reach the bus but still complete each beat with SLVERR
    assign beat_err   = !size_ok_q || timeout_hit;
    assign bus_accept = !size_ok_q || !mst_bus_waitrequest || timeout_hit;
    assign beat_resp  = beat_err ? 2'b10 : mst_bus_response;
    assign beat_rdata = beat_err ? 32'h0 : mst_bus_readdata;
    assign last_beat  = (beat_q == len_q);
    assign next_addr  = fixed_q ? addr_q : addr_q + ADDR_W'(4);

    assign mst_bus_addr       = addr_q & ~ADDR_W'(3);
    assign mst_bus_writedata  = wdata_q;
    assign mst_bus_byteenable = be_q;
    assign slv_axi_bid        = id_q;
    assign slv_axi_bresp      = bresp_q;
    assign slv_axi_rid        = id_q;
    assign slv_axi_rdata      = rdata_q;
    assign slv_axi_rresp      = rresp_q;
    assign slv_axi_rlast      = rlast_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        slv_axi_awready = 1'b0;
        slv_axi_arready = 1'b0;
        slv_axi_wready  = 1'b0;
        slv_axi_bvalid  = 1'b0;
        slv_axi_rvalid  = 1'b0;
        mst_bus_read    = 1'b0;
        mst_bus_write   = 1'b0;
        case (state_q)
            IDLE: begin
                slv_axi_awready = !rst && grant_wr;
                slv_axi_arready = !rst && grant_rd;
                if (grant_wr) begin
                    state_d = WR_DATA;
                end else if (grant_rd) begin
                    state_d = RD_BUS;
                end
            end
            WR_DATA: begin
                slv_axi_wready = 1'b1;
                if (slv_axi_wvalid) begin
                    state_d = WR_BUS;
                end
            end
            WR_BUS: begin
                mst_bus_write = size_ok_q;
                if (bus_accept) begin
                    state_d = last_beat ? WR_RESP : WR_DATA;
                end
            end
            WR_RESP: begin
                slv_axi_bvalid = 1'b1;
                if (slv_axi_bready) begin
                    state_d = IDLE;
                end
            end
            RD_BUS: begin
                mst_bus_read = size_ok_q;
                if (bus_accept) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                slv_axi_rvalid = 1'b1;
                if (slv_axi_rready) begin
                    state_d = rlast_q ? IDLE : RD_BUS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_ok_q <= 1'b0;
            fixed_q   <= 1'b0;
            bresp_q   <= 2'b00;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_wr) begin
                        last_wr_q <= 1'b1;
                        id_q      <= slv_axi_awid;
                        addr_q    <= slv_axi_awaddr;
                        len_q     <= slv_axi_awlen;
                        size_ok_q <= (slv_axi_awsize == 3'b010);
                        fixed_q   <= (slv_axi_awburst == 2'b00);
                        beat_q    <= '0;
                        bresp_q   <= 2'b00;
                    end else if (grant_rd) begin
                        last_wr_q <= 1'b0;
                        id_q      <= slv_axi_arid;
                        addr_q    <= slv_axi_araddr;
                        len_q     <= slv_axi_arlen;
                        size_ok_q <= (slv_axi_arsize == 3'b010);
                        fixed_q   <= (slv_axi_arburst == 2'b00);
                        beat_q    <= '0;
                        be_q      <= 4'hF;
                    end
                end
                WR_DATA: begin
                    if (slv_axi_wvalid) begin
                        wdata_q <= slv_axi_wdata;
                        be_q    <= slv_axi_wstrb;
                    end
                end
                WR_BUS: begin
                    if (bus_accept) begin
                        // Encodings order by severity, so numeric max picks the worst
                        if (beat_resp > bresp_q) begin
                            bresp_q <= beat_resp;
                        end
                        if (!last_beat) begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                RD_BUS: begin
                    if (bus_accept) begin
                        rdata_q <= beat_rdata;
                        rresp_q <= beat_resp;
                        rlast_q <= last_beat;
                    end
                end
                RD_RESP: begin
                    if (slv_axi_rready && !rlast_q) begin
                        addr_q <= next_addr;
                        beat_q <= beat_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_core_bridge.sv
// tb/tb_axi_core_bridge.sv - scoreboard bench for axi_core_bridge
`timescale 1ns/1ps
module tb_axi_core_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp, bus_resp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        bus_read, bus_write, bus_wait;
    logic [3:0]  wstrb, bus_be;

    axi_core_bridge #(.ADDR_W(32), .ID_W(4), .TIMEOUT_CYC(256)) dut (
        .clk(clk), .rst(rst),
        .slv_axi_awid(awid), .slv_axi_awaddr(awaddr), .slv_axi_awlen(awlen),
        .slv_axi_awsize(awsize), .slv_axi_awburst(awburst),
        .slv_axi_awvalid(awvalid), .slv_axi_awready(awready),
        .slv_axi_wdata(wdata), .slv_axi_wstrb(wstrb), .slv_axi_wlast(wlast),
        .slv_axi_wvalid(wvalid), .slv_axi_wready(wready),
        .slv_axi_bid(bid), .slv_axi_bresp(bresp),
        .slv_axi_bvalid(bvalid), .slv_axi_bready(bready),
        .slv_axi_arid(arid), .slv_axi_araddr(araddr), .slv_axi_arlen(arlen),
        .slv_axi_arsize(arsize), .slv_axi_arburst(arburst),
        .slv_axi_arvalid(arvalid), .slv_axi_arready(arready),
        .slv_axi_rid(rid), .slv_axi_rdata(rdata), .slv_axi_rresp(rresp),
        .slv_axi_rlast(rlast), .slv_axi_rvalid(rvalid), .slv_axi_rready(rready),
        .mst_bus_addr(bus_addr), .mst_bus_read(bus_read), .mst_bus_write(bus_write),
        .mst_bus_writedata(bus_wdata), .mst_bus_byteenable(bus_be),
        .mst_bus_readdata(bus_rdata), .mst_bus_response(bus_resp),
        .mst_bus_waitrequest(bus_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          stuck;
    } bus_item_t;
    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_item_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_item_t;

    bus_item_t exp_bus[$];
    r_item_t   exp_r[$];
    b_item_t   exp_b[$];
    bus_item_t bus_it;
    r_item_t   r_it;
    b_item_t   b_it;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bus_waits = 0;
    int rr_stall = 0;
    int stall = 0;
    int rwait = 0;
    int t1, t2, n;
    logic seen;
    logic        hold_pend = 1'b0;
    logic [38:0] hold_pl;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [127:0] out_vec();
        return {awready, wready, bvalid, arready, rvalid, bus_read, bus_write, bus_addr,
                bus_wdata, bus_be, bid, bresp, rid, rdata, rresp, rlast};
    endfunction

    function automatic void push_bus(bit wr, logic [31:0] addr, logic [31:0] wd, logic [3:0] be,
                                     logic [1:0] resp, logic [31:0] rd, bit stuck);
        bus_item_t it;
        it.wr = wr; it.addr = addr; it.wdata = wd; it.be = be;
        it.resp = resp; it.rdata = rd; it.stuck = stuck;
        exp_bus.push_back(it);
    endfunction

    function automatic void push_r(logic [3:0] id, logic [31:0] d, logic [1:0] resp, logic last);
        r_item_t it;
        it.id = id; it.data = d; it.resp = resp; it.last = last;
        exp_r.push_back(it);
    endfunction

    function automatic void push_b(logic [3:0] id, logic [1:0] resp);
        b_item_t it;
        it.id = id; it.resp = resp;
        exp_b.push_back(it);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Core-bus responder: compares each accepted access against the scoreboard
    always @(negedge clk) begin
        if (bus_read || bus_write) begin
            if (exp_bus.size() == 0) begin
                fail_now("bus_unexpected_access");
                bus_wait = 1'b0; bus_rdata = '0; bus_resp = 2'b00;
            end else if (exp_bus[0].stuck) begin
                bus_wait = 1'b1;
            end else if (stall < bus_waits) begin
                bus_wait = 1'b1;
                stall++;
            end else begin
                bus_it = exp_bus.pop_front();
                bus_wait = 1'b0;
                stall = 0;
                chk("bus_kind_addr_be", {bus_write, bus_read, bus_addr, bus_be},
                    {bus_it.wr, !bus_it.wr, bus_it.addr, bus_it.be});
                if (bus_it.wr) chk("bus_writedata", bus_wdata, bus_it.wdata);
                bus_rdata = bus_it.rdata;
                bus_resp  = bus_it.resp;
            end
        end else begin
            bus_wait = 1'b0;
            stall = 0;
        end
    end

    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else begin
                b_it = exp_b.pop_front();
                chk("b_id_resp", {bid, bresp}, {b_it.id, b_it.resp});
            end
        end
    end

    always @(negedge clk) begin
        if (hold_pend) begin
            chk("r_hold_stable", {rvalid, rid, rdata, rresp, rlast}, {1'b1, hold_pl});
            hold_pend = 1'b0;
        end
        if (rvalid) begin
            if (!rready) begin
                hold_pend = 1'b1;
                hold_pl = {rid, rdata, rresp, rlast};
            end else if (exp_r.size() == 0) begin
                fail_now("r_unexpected");
            end else begin
                r_it = exp_r.pop_front();
                chk("r_beat", {rid, rdata, rresp, rlast}, {r_it.id, r_it.data, r_it.resp, r_it.last});
            end
        end
    end

    initial begin
        rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rvalid) begin
                if (rwait < rr_stall) begin rready = 1'b0; rwait++; end
                else begin rready = 1'b1; rwait = 0; end
            end else begin
                rready = 1'b0; rwait = 0;
            end
        end
    end

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                             input logic [15:0] strbs, output int t_aw);
        int k;
        t_aw = 0;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && k < 200);
        t_aw = cyc;
        if (!awready) begin fail_now("aw_handshake_bound"); awvalid = 1'b0; return; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = base + b; wstrb = strbs[(b % 4) * 4 +: 4]; wlast = (b == int'(len));
            k = 0;
            do begin @(negedge clk); k++; end while (!wready && k < 200);
            if (!wready) begin fail_now("w_handshake_bound"); wvalid = 1'b0; return; end
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output int t_ar);
        int k;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!arready && k < 200);
        t_ar = cyc;
        if (!arready) fail_now("ar_handshake_bound");
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((exp_bus.size() + exp_r.size() + exp_b.size()) != 0 && k < 500) begin
            @(negedge clk); k++;
        end
        if ((exp_bus.size() + exp_r.size() + exp_b.size()) != 0) fail_now("drain_bound");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input bit want_b, output int t);
        int k = 0;
        t = 0;
        while (!(want_b ? bvalid : rvalid) && k < 400) begin @(negedge clk); k++; end
        if (!(want_b ? bvalid : rvalid)) fail_now("valid_bound");
        t = cyc;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; bready = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bus_rdata = '0; bus_resp = 2'b00; bus_wait = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", out_vec(), 128'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single write, zero-wait bus
        push_bus(1, 32'h100, 32'hA5A5_0001, 4'hF, 2'b00, 32'h0, 0);
        push_b(4'd3, 2'b00);
        axi_write(4'd3, 32'h100, 8'd0, 3'b010, 2'b01, 32'hA5A5_0001, 16'h000F, t1);
        wait_valid(1, t);
        chk("write_b_latency", t - t1, 3);
        wait_done();

        // Single read, unaligned address masked to the word
        push_bus(0, 32'h104, 32'h0, 4'hF, 2'b00, 32'h1234_5678, 0);
        push_r(4'd2, 32'h1234_5678, 2'b00, 1'b1);
        axi_read(4'd2, 32'h107, 8'd0, 3'b010, 2'b01, t1);
        wait_valid(0, t);
        chk("read_r_latency", t - t1, 2);
        wait_done();

        // INCR burst with SLVERR on beat 2
        for (int i = 0; i < 4; i++)
            push_bus(1, 32'h200 + 4 * i, 32'h1111_0000 + i, (i == 1) ? 4'h3 : (i == 2) ? 4'hC : 4'hF,
                     (i == 2) ? 2'b10 : 2'b00, 32'h0, 0);
        push_b(4'd5, 2'b10);
        axi_write(4'd5, 32'h200, 8'd3, 3'b010, 2'b01, 32'h1111_0000, 16'hFC3F, t1);
        wait_done();

        // FIXED read, 3 wait cycles per beat, rready stalled
        bus_waits = 3; rr_stall = 2;
        push_bus(0, 32'h40, 32'h0, 4'hF, 2'b00, 32'hDEAD_0001, 0);
        push_bus(0, 32'h40, 32'h0, 4'hF, 2'b00, 32'hDEAD_0002, 0);
        push_r(4'd7, 32'hDEAD_0001, 2'b00, 1'b0);
        push_r(4'd7, 32'hDEAD_0002, 2'b00, 1'b1);
        axi_read(4'd7, 32'h40, 8'd1, 3'b010, 2'b00, t1);
        wait_valid(0, t);
        chk("read_wait_latency", t - t1, 5);
        wait_done();
        bus_waits = 0; rr_stall = 0;

        // Arbitration from reset: write first
        do_reset();
        push_bus(1, 32'h500, 32'h5000_0000, 4'hF, 2'b00, 32'h0, 0);
        push_bus(0, 32'h600, 32'h0, 4'hF, 2'b00, 32'h6666_0000, 0);
        push_b(4'd1, 2'b00);
        push_r(4'd2, 32'h6666_0000, 2'b00, 1'b1);
        fork
            axi_write(4'd1, 32'h500, 8'd0, 3'b010, 2'b01, 32'h5000_0000, 16'h000F, t1);
            axi_read(4'd2, 32'h600, 8'd0, 3'b010, 2'b01, t2);
        join
        wait_done();
        chk("arb_write_first", t2 > t1, 1);

        // After a lone write, contention favours read
        push_bus(1, 32'h700, 32'h7000_0000, 4'hF, 2'b00, 32'h0, 0);
        push_b(4'd1, 2'b00);
        axi_write(4'd1, 32'h700, 8'd0, 3'b010, 2'b01, 32'h7000_0000, 16'h000F, t1);
        wait_done();
        push_bus(0, 32'h900, 32'h0, 4'hF, 2'b00, 32'h9999_0000, 0);
        push_bus(1, 32'h800, 32'h8000_0000, 4'hF, 2'b00, 32'h0, 0);
        push_r(4'd4, 32'h9999_0000, 2'b00, 1'b1);
        push_b(4'd3, 2'b00);
        fork
            axi_write(4'd3, 32'h800, 8'd0, 3'b010, 2'b01, 32'h8000_0000, 16'h000F, t1);
            axi_read(4'd4, 32'h900, 8'd0, 3'b010, 2'b01, t2);
        join
        wait_done();
        chk("arb_read_first", t2 < t1, 1);

        // Unsupported size: no bus access, SLVERR beats with zero data
        push_r(4'd9, 32'h0, 2'b10, 1'b0);
        push_r(4'd9, 32'h0, 2'b10, 1'b1);
        axi_read(4'd9, 32'hA00, 8'd1, 3'b001, 2'b01, t1);
        wait_done();

        // Waitrequest stuck high
        push_bus(0, 32'hB00, 32'h0, 4'hF, 2'b00, 32'h0, 1);
        axi_read(4'd6, 32'hB00, 8'd0, 3'b010, 2'b01, t1);
`ifdef AXI_CORE_BRIDGE_TIMEOUT_EN
        push_r(4'd6, 32'h0, 2'b10, 1'b1);
        wait_valid(0, t);
        chk("timeout_latency", t - t1, 257);
        repeat (3) @(negedge clk);
        chk("timeout_r_drained", exp_r.size(), 0);
        exp_bus.delete();
`else
        seen = 1'b0;
        repeat (300) begin @(negedge clk); seen = seen | rvalid; end
        chk("no_timeout_rvalid", seen, 0);
        chk("read_still_pending", bus_read, 1);
        do_reset();
        exp_bus.delete();
`endif

        // Reset in the middle of a read burst
        push_bus(0, 32'hC00, 32'h0, 4'hF, 2'b00, 32'hC0C0_0000, 0);
        push_bus(0, 32'hC04, 32'h0, 4'hF, 2'b00, 32'h0, 1);
        push_r(4'd8, 32'hC0C0_0000, 2'b00, 1'b0);
        axi_read(4'd8, 32'hC00, 8'd3, 3'b010, 2'b01, t1);
        n = 0;
        while (!(exp_r.size() == 0 && bus_read) && n < 100) begin @(negedge clk); n++; end
        chk("mid_burst_reached", {exp_r.size() == 0, bus_read}, 2'b11);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_mid_burst", out_vec(), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_bus.delete();
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen = seen | rvalid | bvalid | bus_read | bus_write; end
        chk("post_reset_quiet", seen, 0);

        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("r_queue_empty", exp_r.size(), 0);
        chk("b_queue_empty", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
